// File: rtl/if_stage_fetch_queue.sv
// Instruction fetch stage: PC, variable-latency imem port, DEPTH-entry fetch queue, IF/ID register.
// rvalid->IF/ID one edge (same edge with IF_QUEUE_BYPASS_EN); stall holds IF/ID, imem_req gated by queue+outstanding<DEPTH.
module if_stage_fetch_queue #(
  parameter int            AW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          if_id_valid,
  output logic [31:0]   if_id_instr,
  output logic [AW-1:0] if_id_pc_plus4
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pcPlus4;
  } fqEntry_t;

  fqEntry_t      fq [DEPTH];
  logic [AW-1:0] addrFifo [DEPTH];
  logic [PW-1:0] fqRd, fqWr, afRd, afWr;
  logic [CW-1:0] fqCount, outstanding, discard, outstandingNext;
  logic [CW:0]   inFlight;
  logic [AW-1:0] pc;
  logic          grant, respKeep, fqEmpty, bypass, fqPush, fqPop;

  always_comb begin
    inFlight        = {1'b0, fqCount} + {1'b0, outstanding};
    imem_req        = !rst && !branch_taken && (inFlight < DEPTH_S);
    imem_addr       = pc;
    grant           = imem_req && imem_gnt;
    outstandingNext = outstanding + CW'(grant) - CW'(imem_rvalid);
    respKeep        = imem_rvalid && (discard == '0);
    fqEmpty         = (fqCount == '0);
`ifdef IF_QUEUE_BYPASS_EN
    bypass          = respKeep && fqEmpty && !stall && !branch_taken;
`else
    bypass          = 1'b0;
`endif
    fqPush          = respKeep && !branch_taken && !bypass;
    fqPop           = !branch_taken && !stall && !fqEmpty;
  end

  // Storage arrays carry no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (grant) addrFifo[afWr] <= pc + AW'(4);
    if (fqPush) fq[fqWr] <= '{instr: imem_rdata, pcPlus4: addrFifo[afRd]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fqRd        <= '0;
      fqWr        <= '0;
      fqCount     <= '0;
      afRd        <= '0;
      afWr        <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (branch_taken) begin
        // Everything still in flight after this edge belongs to the old path.
        pc      <= branch_target;
        discard <= outstandingNext;
        fqRd    <= '0;
        fqWr    <= '0;
        fqCount <= '0;
        afRd    <= '0;
        afWr    <= '0;
      end else begin
        if (grant) begin
          pc   <= pc + AW'(4);
          afWr <= afWr + 1'b1;
        end
        if (imem_rvalid) begin
          if (discard != '0) discard <= discard - 1'b1;
          else afRd <= afRd + 1'b1;
        end
        if (fqPush) fqWr <= fqWr + 1'b1;
        if (fqPop) fqRd <= fqRd + 1'b1;
        fqCount <= fqCount + CW'(fqPush) - CW'(fqPop);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
    end else if (branch_taken) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
    end else if (stall) begin
      if_id_valid    <= if_id_valid;
      if_id_instr    <= if_id_instr;
      if_id_pc_plus4 <= if_id_pc_plus4;
    end else if (bypass) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= imem_rdata;
      if_id_pc_plus4 <= addrFifo[afRd];
    end else if (!fqEmpty) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= fq[fqRd].instr;
      if_id_pc_plus4 <= fq[fqRd].pcPlus4;
    end else begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
    end
  end
endmodule

// File: tb/tb_if_stage_fetch_queue.sv
// Randomized bench for if_stage_fetch_queue: queue-level reference model plus IF/ID scoreboard.
module tb_if_stage_fetch_queue;
  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;
`ifdef IF_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          stall = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          if_id_valid;
  logic [31:0]   if_id_instr;
  logic [AW-1:0] if_id_pc_plus4;

  always #5 clk = ~clk;

  if_stage_fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4)
  );

  typedef struct { logic [31:0] instr; logic [31:0] pcp4; } ent_t;
  typedef struct { logic [31:0] pcp4; bit stale; } infl_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } mem_t;
  typedef struct { bit v; logic [31:0] instr; logic [31:0] pcp4; } ifid_t;

  ent_t        mFq[$];
  infl_t       mInfl[$];
  mem_t        memQ[$];
  ifid_t       expQ[$];
  logic [31:0] mPc;
  ifid_t       mIfid;
  logic [31:0] dataCtr = 32'h20080001;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check request side, advance the model at posedge.
  task automatic step(input bit bt, input logic [31:0] tgt, input bit st, input bit g, input bit rv);
    bit          mReq, respOk, dutReq;
    logic [31:0] dutAddr;
    ent_t        resp, e;
    infl_t       r;
    branch_taken  = bt;
    branch_target = tgt;
    stall         = st;
    imem_gnt      = g;
    imem_rvalid   = rv && (memQ.size() > 0);
    imem_rdata    = imem_rvalid ? memQ[0].data : 32'hDEADBEEF;
    #1;
    mReq = !bt && (mFq.size() + mInfl.size() < DEPTH);
    chk("imem_req", 64'(imem_req), 64'(mReq));
    chk("imem_addr", 64'(imem_addr), 64'(mPc));
    dutReq  = imem_req;
    dutAddr = imem_addr;
    @(posedge clk);
    if (imem_rvalid) void'(memQ.pop_front());
    if (dutReq && g) begin
      memQ.push_back('{dutAddr, dataCtr});
      dataCtr = dataCtr + 32'd1;
    end
    respOk = 1'b0;
    resp   = '{32'h0, 32'h0};
    if (imem_rvalid && mInfl.size() > 0) begin
      r      = mInfl.pop_front();
      respOk = !r.stale;
      resp   = '{imem_rdata, r.pcp4};
    end
    if (bt) mIfid = '{1'b0, 32'h0, 32'h0};
    else if (st) mIfid = mIfid;
    else if (BYP && respOk && mFq.size() == 0) begin
      mIfid  = '{1'b1, resp.instr, resp.pcp4};
      respOk = 1'b0;
    end else if (mFq.size() > 0) begin
      e     = mFq.pop_front();
      mIfid = '{1'b1, e.instr, e.pcp4};
    end else mIfid = '{1'b0, 32'h0, 32'h0};
    if (bt) begin
      mFq.delete();
      foreach (mInfl[i]) mInfl[i].stale = 1'b1;
      mPc = tgt;
    end else begin
      if (respOk) mFq.push_back(resp);
      if (mReq && g) begin
        mInfl.push_back('{mPc + 32'd4, 1'b0});
        mPc = mPc + 32'd4;
      end
    end
    expQ.push_back(mIfid);
    @(negedge clk);
  endtask

  task automatic modelReset();
    mPc   = RPC;
    mIfid = '{1'b0, 32'h0, 32'h0};
    mFq.delete();
    mInfl.delete();
    memQ.delete();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic midReset();
    #3;
    rst          = 1'b1;
    branch_taken = 1'b0;
    stall        = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    #1;
    chk("rst_req", 64'(imem_req), 64'(0));
    chk("rst_valid", 64'(if_id_valid), 64'(0));
    chk("rst_instr", 64'(if_id_instr), 64'(0));
    chk("rst_pcp4", 64'(if_id_pc_plus4), 64'(0));
    chk("rst_addr", 64'(imem_addr), 64'(RPC));
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic randomSteps(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
  endtask

  initial begin : monitor
    ifid_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("if_id_valid", 64'(if_id_valid), 64'(e.v));
        chk("if_id_instr", 64'(if_id_instr), 64'(e.instr));
        chk("if_id_pc_plus4", 64'(if_id_pc_plus4), 64'(e.pcp4));
      end
    end
  end

  initial begin : driver
    modelReset();
    repeat (2) @(negedge clk);
    chk("init_req", 64'(imem_req), 64'(0));
    chk("init_valid", 64'(if_id_valid), 64'(0));
    chk("init_pcp4", 64'(if_id_pc_plus4), 64'(0));
    rst = 1'b0;
    // Streaming, rvalid one cycle after each grant.
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Long stall fills queue to capacity, then release.
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Redirect with two outstanding, under stall.
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Redirect coinciding with an rvalid.
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h80, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Memory busy: grant withheld.
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // PC wrap-around.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    randomSteps(400);
    // Partially fill the queue, then reset asynchronously.
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    midReset();
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    randomSteps(200);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_stage_fetch_queue.md
Name: if_stage_fetch_queue

Overview:
- Parametrised successor to the single-register instruction fetch stage.
- Owns the PC and issues word fetches to an external instruction memory port with variable latency (req/gnt/rvalid).
- Buffers responses in a DEPTH-entry fetch queue, then presents an IF/ID pipeline register with a valid bit to decode.
- Handles hazard-unit stalls and branch redirects, including discarding stale in-flight responses.

Parameters:
AW, 32, PC / address width in bits (instruction width fixed at 32)
DEPTH, 4, fetch queue entries; power of two, >=2; also the cap on outstanding requests
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset; asynchronous, active-high
branch_taken  in  1  redirect request from EX (flush)
branch_target  in  AW  redirect PC
stall  in  1  hazard-unit stall; hold IF/ID register
imem_req  out  1  fetch request
imem_addr  out  AW  fetch byte address (= pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction
if_id_valid  out  1  IF/ID register holds a real instruction
if_id_instr  out  32  IF/ID instruction
if_id_pc_plus4  out  AW  IF/ID fetch address + 4

Behaviour:
- Reset (async, any time, including mid-transfer):
  - pc = RESET_PC; queue empty; outstanding = 0; discard = 0.
  - if_id_valid = 0; if_id_instr = 0; if_id_pc_plus4 = 0.
  - imem_req = 0 while rst is high.
- Request issue:
  - imem_req = !rst && !branch_taken && (queue_count + outstanding < DEPTH).
  - imem_addr = pc.
  - Each cycle with imem_req && imem_gnt: pc += 4 (wraps mod 2^AW) and outstanding += 1.
- Responses:
  - Responses return in order. rvalid never occurs in the same cycle as its own gnt; the bench enforces this.
  - Each imem_rvalid decrements outstanding.
  - If discard > 0: drop the response and decrement discard.
  - Otherwise push {imem_rdata, addr+4} into the queue. Addr is tracked in a DEPTH-entry address FIFO written on grant.
- IF/ID register update, priority order:
  1. branch_taken: if_id_valid = 0 and fields cleared. Flush overrides stall.
  2. stall: hold all three fields unchanged; no pop.
  3. Queue non-empty: pop head into IF/ID; if_id_valid = 1.
  4. Queue empty: if_id_valid = 0 (bubble); fields cleared.
- Redirect (branch_taken sampled high):
  - pc = branch_target; queue and address FIFO cleared.
  - discard = outstanding after this cycle's update, i.e. outstanding minus 1 if rvalid is this cycle. A response arriving this cycle is itself dropped.
  - imem_req is 0 that cycle, so no grant collides with the redirect.
  - Redirect while discard > 0 adds the remaining outstanding count; discard never exceeds DEPTH.
- Latency without bypass:
  - Response sampled at edge t is queued.
  - It appears in IF/ID at edge t+1 if not stalled.
- Boundaries:
  - Queue full plus outstanding at cap → imem_req = 0.
  - Pop and push in the same cycle are both allowed with count unchanged; legal when full.
  - Stall with a full queue keeps imem_req at 0 and drops no data.
  - branch_target is used as given; it must be word-aligned. Low two bits are passed through unchecked.

Optional Feature:
IF_QUEUE_BYPASS_EN
- Defined: when the queue is empty, !stall, !branch_taken, and a non-discarded rvalid arrives, the response loads IF/ID directly at that edge (latency 0 edges after rvalid) and is not queued.
- Undefined: every response goes through the queue. This gives the one-edge latency described above.
- Flush and stall priority are identical in both builds.

Test Plan:
- Reset, gnt=1 always, rvalid one cycle after each gnt, rdata=0x20080001,... → imem_addr 0,4,8,...; if_id_pc_plus4 = 4,8,12 in order; if_id_valid = 1 from the 3rd edge after first gnt (2nd with bypass).
- stall held 6 cycles, DEPTH=4 → exactly 4 requests outstanding/queued, then imem_req = 0; IF/ID unchanged. Release → 4 instructions delivered back-to-back in order.
- branch_taken with 2 outstanding, target 0x40 → both late responses dropped; next if_id_valid instruction has pc_plus4 = 0x44; IF/ID cleared at redirect edge even with stall=1.
- Redirect in the same cycle as an rvalid → that response is dropped; discard = outstanding - 1; no stale instruction reaches IF/ID.
- gnt withheld 5 cycles (memory busy) → imem_req stays 1, imem_addr stable; pc unchanged; if_id_valid = 0 bubbles.
- Assert rst mid-stream with queue half full → all outputs 0 immediately (async); after release, fetch restarts at RESET_PC = 0x100 when overridden.
